// File: rtl/design_select_mux.sv
// Purpose : glitch-free registered select mux routing one of NUM_CH design buses to shared pads.
//           Every committed selection change inserts BLANK_CYCLES of IDLE_VALUE with all enables low.
// Ports   : clk, rst_n (async active-low); sel_in (async pad select), sel_lock_in (freeze selection),
//           ch_data_in (flattened channel buses); mux_out, ch_en_out, active_sel_out, switching_out,
//           sel_err_out (synchronised select out of range).
module design_select_mux #(
  parameter int NUM_CH       = 8,
  parameter int WIDTH        = 11,
  parameter int SEL_W        = $clog2(NUM_CH),
  parameter int SYNC_STAGES  = 2,
  parameter int BLANK_CYCLES = 4,
  parameter logic [WIDTH-1:0] IDLE_VALUE = {WIDTH{1'b0}}
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SEL_W-1:0]        sel_in,
  input  logic                    sel_lock_in,
  input  logic [NUM_CH*WIDTH-1:0] ch_data_in,
  output logic [WIDTH-1:0]        mux_out,
  output logic [NUM_CH-1:0]       ch_en_out,
  output logic [SEL_W-1:0]        active_sel_out,
  output logic                    switching_out,
  output logic                    sel_err_out
);

  localparam int CNT_W = $clog2(BLANK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BLANK_CYCLES - 1);
  // One extra bit so the range check also works when NUM_CH is a power of two.
  localparam logic [SEL_W:0]   NUM_CH_W   = (SEL_W + 1)'(NUM_CH);

  typedef enum logic {ST_ACTIVE, ST_BLANK} state_t;

  // Select synchroniser
  logic [SEL_W-1:0] sync_q [SYNC_STAGES];
  logic [SEL_W-1:0] sel_s;
  logic             sel_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= sel_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sel_s     = sync_q[SYNC_STAGES-1];
  assign sel_valid = ({1'b0, sel_s} < NUM_CH_W);

  // Channel unpack
  logic [WIDTH-1:0] ch_dat [NUM_CH];
  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign ch_dat[g] = ch_data_in[g*WIDTH +: WIDTH];
  end

  // Control state
  state_t             state_q, state_d;
  logic [SEL_W-1:0]   active_q, active_d;
  logic [SEL_W-1:0]   pending_q, pending_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mux_q, mux_d;
  logic [NUM_CH-1:0]  en_q, en_d;
  logic               sw_q, sw_d;
  logic               err_q, err_d;

  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    mux_d     = mux_q;
    en_d      = en_q;
    sw_d      = sw_q;
    err_d     = !sel_valid;

    case (state_q)
      ST_ACTIVE: begin
        if (sel_valid && (sel_s != active_q) && !sel_lock_in) begin
          state_d   = ST_BLANK;
          pending_d = sel_s;
          cnt_d     = CNT_RELOAD;
          mux_d     = IDLE_VALUE;
          en_d      = '0;
          sw_d      = 1'b1;
        end else begin
          // Invalid or locked selects keep the committed channel routed.
          mux_d = ch_dat[active_q];
          en_d  = NUM_CH'(1) << active_q;
          sw_d  = 1'b0;
        end
      end
      ST_BLANK: begin
        mux_d = IDLE_VALUE;
        en_d  = '0;
        sw_d  = 1'b1;
        if (sel_valid && (sel_s != pending_q)) begin
          // Target moved: restart the full blank, even if it moved back to the old channel.
          pending_d = sel_s;
          cnt_d     = CNT_RELOAD;
        end else if (cnt_q == '0) begin
          state_d  = ST_ACTIVE;
          active_d = pending_q;
          mux_d    = ch_dat[pending_q];
          en_d     = NUM_CH'(1) << pending_q;
          sw_d     = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_BLANK;
      active_q  <= '0;
      pending_q <= '0;
      cnt_q     <= CNT_RELOAD;
      mux_q     <= IDLE_VALUE;
      en_q      <= '0;
      sw_q      <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      mux_q     <= mux_d;
      en_q      <= en_d;
      sw_q      <= sw_d;
      err_q     <= err_d;
    end
  end

  assign mux_out        = mux_q;
  assign ch_en_out      = en_q;
  assign active_sel_out = active_q;
  assign switching_out  = sw_q;
  assign sel_err_out    = err_q;

endmodule

// File: tb/tb_design_select_mux.sv
module tb_design_select_mux;

  localparam int BLANK = 4;
  localparam int SYNC  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  sel0, sel1;
  logic        lock0, lock1;
  logic [10:0] dat [8];
  logic [87:0] flat0;
  logic [65:0] flat1;

  logic [10:0] mux0, mux1;
  logic [7:0]  en0;
  logic [5:0]  en1;
  logic [2:0]  act0, act1;
  logic        sw0, sw1, err0, err1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  always_comb begin
    flat0 = '0;
    flat1 = '0;
    for (int i = 0; i < 8; i++) flat0[i*11 +: 11] = dat[i];
    for (int i = 0; i < 6; i++) flat1[i*11 +: 11] = dat[i];
  end

  // Default configuration
  design_select_mux u_dut0 (
    .clk(clk), .rst_n(rst_n), .sel_in(sel0), .sel_lock_in(lock0), .ch_data_in(flat0),
    .mux_out(mux0), .ch_en_out(en0), .active_sel_out(act0), .switching_out(sw0), .sel_err_out(err0)
  );

  // Six channels, so select codes 6 and 7 are out of range
  design_select_mux #(.NUM_CH(6)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sel_in(sel1), .sel_lock_in(lock1), .ch_data_in(flat1),
    .mux_out(mux1), .ch_en_out(en1), .active_sel_out(act1), .switching_out(sw1), .sel_err_out(err1)
  );

  // Behavioural model, one slot per DUT. It tracks "which channel is on the pads"
  // and "how many idle cycles are still owed" rather than any FSM encoding.
  int          m_pipe [2][SYNC];
  bit          m_blanking [2];
  int          m_owed [2];
  int          m_target [2];
  int          m_act [2];
  logic [10:0] e_mux [2];
  logic [7:0]  e_en [2];
  bit          e_sw [2];
  bit          e_err [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < SYNC; s++) m_pipe[k][s] = 0;
      m_blanking[k] = 1;
      m_owed[k]     = BLANK - 1;
      m_target[k]   = 0;
      m_act[k]      = 0;
      e_mux[k]      = 11'h000;
      e_en[k]       = 8'h00;
      e_sw[k]       = 1;
      e_err[k]      = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int nch  = (k == 0) ? 8 : 6;
      int seen = m_pipe[k][SYNC-1];
      int raw  = (k == 0) ? int'(sel0) : int'(sel1);
      bit lk   = (k == 0) ? lock0 : lock1;
      bit ok   = seen < nch;
      for (int s = SYNC - 1; s > 0; s--) m_pipe[k][s] = m_pipe[k][s-1];
      m_pipe[k][0] = raw;
      e_err[k] = !ok;
      if (!m_blanking[k]) begin
        if (ok && seen != m_act[k] && !lk) begin
          m_blanking[k] = 1; m_target[k] = seen; m_owed[k] = BLANK - 1;
          e_mux[k] = 11'h000; e_en[k] = 8'h00; e_sw[k] = 1;
        end else begin
          e_mux[k] = dat[m_act[k]]; e_en[k] = 8'(1 << m_act[k]); e_sw[k] = 0;
        end
      end else if (ok && seen != m_target[k]) begin
        m_target[k] = seen; m_owed[k] = BLANK - 1;
      end else if (m_owed[k] == 0) begin
        m_blanking[k] = 0; m_act[k] = m_target[k];
        e_mux[k] = dat[m_act[k]]; e_en[k] = 8'(1 << m_act[k]); e_sw[k] = 0;
      end else begin
        m_owed[k]--;
      end
    end
  endtask

  // Advance one clock: model follows the rising edge, the bench resumes on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sel0 = 3'd0; sel1 = 3'd0; lock0 = 1'b0; lock1 = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (mux0 !== 11'h000 || en0 !== 8'h00 || sw0 !== 1'b1 || act0 !== 3'd0 || err0 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: mux=%h en=%b sw=%b act=%0d err=%b, want 000 00000000 1 0 0", mux0, en0, sw0, act0, err0);
    end
    tick(); tick();
    rst_n = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      logic [10:0] want_mux = (n < BLANK) ? 11'h000 : 11'h100;
      logic        want_sw  = (n < BLANK);
      tick();
      vectors++;
      if (mux0 !== want_mux || sw0 !== want_sw || mux0 !== e_mux[0]) begin
        miscompares++;
        $display("FAIL reset_release edge %0d: mux=%h sw=%b, want mux=%h sw=%b", n, mux0, sw0, want_mux, want_sw);
      end
    end
    vectors++;
    if (en0 !== 8'b0000_0001 || act0 !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_release_en: en=%b act=%0d, want 00000001 0", en0, act0);
    end
  endtask

  task automatic test_switch();
    sel0 = 3'd5;
    for (int n = 1; n <= 8; n++) begin
      logic [10:0] want_mux = (n < SYNC + 1) ? 11'h100 : (n < SYNC + 1 + BLANK) ? 11'h000 : 11'h105;
      logic        want_sw  = (n >= SYNC + 1) && (n < SYNC + 1 + BLANK);
      tick();
      vectors++;
      if (mux0 !== want_mux || sw0 !== want_sw) begin
        miscompares++;
        $display("FAIL normal_switch edge %0d: mux=%h sw=%b, want mux=%h sw=%b", n, mux0, sw0, want_mux, want_sw);
      end
    end
    vectors++;
    if (en0 !== 8'b0010_0000 || act0 !== 3'd5) begin
      miscompares++;
      $display("FAIL normal_switch_en: en=%b act=%0d, want 00100000 5", en0, act0);
    end
  endtask

  task automatic test_change_during_blank();
    int idle = 0;
    sel0 = 3'd2;
    tick(); tick();
    sel0 = 3'd7;
    // Edges 1-2 already passed; blank enters at 3, restarts at 5, commits at 9.
    for (int n = 3; n <= 12; n++) begin
      logic [10:0] want_mux = (n < 9) ? 11'h000 : 11'h107;
      tick();
      if (mux0 == 11'h000) idle++;
      vectors++;
      if (mux0 !== want_mux || mux0 === 11'h102) begin
        miscompares++;
        $display("FAIL blank_restart edge %0d: mux=%h, want %h", n, mux0, want_mux);
      end
    end
    vectors++;
    if (idle != 6) begin
      miscompares++;
      $display("FAIL blank_restart_idle: idle cycles=%0d, want 6", idle);
    end
  endtask

  task automatic test_lock();
    lock0 = 1'b1; sel0 = 3'd1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      vectors++;
      if (mux0 !== 11'h107 || sw0 !== 1'b0) begin
        miscompares++;
        $display("FAIL lock_hold edge %0d: mux=%h sw=%b, want 107 0", n, mux0, sw0);
      end
    end
    lock0 = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      logic [10:0] want_mux = (n <= BLANK) ? 11'h000 : 11'h101;
      tick();
      vectors++;
      if (mux0 !== want_mux || sw0 !== (n <= BLANK)) begin
        miscompares++;
        $display("FAIL lock_release edge %0d: mux=%h sw=%b, want mux=%h", n, mux0, sw0, want_mux);
      end
    end
  endtask

  task automatic test_out_of_range();
    sel1 = 3'd7;
    for (int n = 1; n <= 8; n++) begin
      logic want_err = (n >= SYNC + 1);
      tick();
      vectors++;
      if (err1 !== want_err || mux1 !== 11'h100 || sw1 !== 1'b0 || en1 !== 6'b000001) begin
        miscompares++;
        $display("FAIL out_of_range edge %0d: err=%b mux=%h sw=%b en=%b, want err=%b mux=100 sw=0 en=000001",
                 n, err1, mux1, sw1, en1, want_err);
      end
    end
    sel1 = 3'd0;
    for (int n = 1; n <= 4; n++) tick();
    vectors++;
    if (err1 !== 1'b0 || mux1 !== 11'h100) begin
      miscompares++;
      $display("FAIL out_of_range_clear: err=%b mux=%h, want 0 100", err1, mux1);
    end
  endtask

  task automatic test_mid_blank_reset();
    sel0 = 3'd3;
    for (int n = 1; n <= 4; n++) tick();
    vectors++;
    if (sw0 !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_blank_entry: sw=%b, want 1", sw0);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (mux0 !== 11'h000 || en0 !== 8'h00 || sw0 !== 1'b1 || act0 !== 3'd0 || err0 !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_blank_reset: mux=%h en=%b sw=%b act=%0d err=%b, want 000 00000000 1 0 0", mux0, en0, sw0, act0, err0);
    end
    test_reset();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 8; i++) dat[i] = 11'($urandom);
      if ($urandom_range(0, 7) == 0) sel0 = 3'($urandom);
      if ($urandom_range(0, 7) == 0) sel1 = 3'($urandom);
      lock0 = ($urandom_range(0, 3) == 0);
      lock1 = ($urandom_range(0, 3) == 0);
      tick();
      vectors++;
      if (mux0 !== e_mux[0] || en0 !== e_en[0] || act0 !== 3'(m_act[0]) || sw0 !== e_sw[0] || err0 !== e_err[0]) begin
        miscompares++;
        $display("FAIL random dut0 cycle %0d: mux=%h en=%b act=%0d sw=%b err=%b, want %h %b %0d %b %b",
                 n, mux0, en0, act0, sw0, err0, e_mux[0], e_en[0], m_act[0], e_sw[0], e_err[0]);
      end
      vectors++;
      if (mux1 !== e_mux[1] || en1 !== e_en[1][5:0] || act1 !== 3'(m_act[1]) || sw1 !== e_sw[1] || err1 !== e_err[1]) begin
        miscompares++;
        $display("FAIL random dut1 cycle %0d: mux=%h en=%b act=%0d sw=%b err=%b, want %h %b %0d %b %b",
                 n, mux1, en1, act1, sw1, err1, e_mux[1], e_en[1][5:0], m_act[1], e_sw[1], e_err[1]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) dat[i] = 11'(32'h100 + i);
    @(negedge clk);
    test_reset();
    test_switch();
    test_change_during_blank();
    test_lock();
    test_out_of_range();
    test_mid_blank_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
